pll_reset_sequencer: RTL and testbench

Supervises the system PLL. It pulses the PLL reset, waits for lock, and qualifies lock stability. It then releases the downstream clock-domain resets in a fixed staggered order. Runs on the free-running 100 MHz reference clock that also feeds the PLL. It detects loss of lock, recovers automatically, and enters a fault state after repeated lock failures.

---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 14 +
 rtl/pll_reset_sequencer.sv | 92 +++++++++
 tb/tb_pll_reset_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: sequencer state encodings and shared-counter width helper
package pll_seq_pkg;
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;
  function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                   input int stable_cycles, input int release_cycles);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    if (release_cycles > m) m = release_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: W-bit two-flop synchronizer (clk, rst -> d to q, reset value 0)
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock supervisor (refclk, rst, pll_locked, reconfig_req -> pll_rst, domain_rst, ready, fault, state_o, lock_loss_cnt)
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int LOSS_W         = 8
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   reconfig_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   fault,
  output logic [2:0]             state_o,
  output logic [LOSS_W-1:0]      lock_loss_cnt
);
  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGGER_CYCLES * NUM_DOMAINS);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] RST_END = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_END = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_END = CW'(STAGGER_CYCLES * NUM_DOMAINS - 1);
  localparam logic [RW-1:0] MAXR    = RW'(MAX_RETRIES);
  state_t                   st, nxt;
  logic [CW-1:0]            cnt;
  logic [RW-1:0]            retry, retry_n;
  logic [NUM_DOMAINS-1:0]   dr_n;
  logic                     lock_s, loss;
  sync_2ff #(.W(1)) u_sync (.clk(refclk), .rst(rst), .d(pll_locked), .q(lock_s));
  assign state_o = st;
  always_comb begin
    nxt = st;
    retry_n = retry;
    loss = 1'b0;
    dr_n = '1;
    if (reconfig_req && st != PLL_RST) begin
      nxt = PLL_RST;
      retry_n = '0;
    end else begin
      case (st)
        PLL_RST:   nxt = (cnt == RST_END) ? WAIT_LOCK : PLL_RST;
        WAIT_LOCK: if (lock_s) nxt = STABLE;
                   else if (cnt == TMO_END) begin
                     nxt = (retry == MAXR) ? FAULT : PLL_RST;
                     retry_n = (retry == MAXR) ? retry : retry + 1'b1;
                   end
        STABLE:    if (!lock_s) nxt = WAIT_LOCK;
                   else if (cnt == STB_END) begin
                     nxt = RELEASE;
                     retry_n = '0;
                   end
        RELEASE, RUN: if (!lock_s) begin
                     nxt = PLL_RST;
                     loss = 1'b1;
                   end else if (st == RELEASE && cnt == REL_END) nxt = RUN;
        FAULT:     nxt = FAULT;
        default:   nxt = PLL_RST;
      endcase
    end
    for (int i = 0; i < NUM_DOMAINS; i++)
      dr_n[i] = !(nxt == RUN || (nxt == RELEASE && st == RELEASE &&
                  int'(cnt) + 1 >= (i + 1) * STAGGER_CYCLES));
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      st <= PLL_RST;
      cnt <= '0;
      retry <= '0;
      pll_rst <= 1'b1;
      domain_rst <= '1;
      ready <= 1'b0;
      fault <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= (nxt != st) ? '0 : cnt + 1'b1;
      retry <= retry_n;
      pll_rst <= nxt == PLL_RST;
      domain_rst <= dr_n;
      ready <= st == RUN && nxt == RUN;
      fault <= nxt == FAULT;
      if (loss && lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: randomized scenario bench with timeline reference model
module tb_pll_reset_sequencer;
  localparam int N = 4, RSTC = 4, TMO = 50, STB = 10, STG = 3, MAXR = 2, MAXT = 512;
  logic refclk = 1'b0, rst = 1'b1, pll_locked = 1'b0, reconfig_req = 1'b0;
  logic pll_rst, ready, fault, pll_rst2, ready2, fault2;
  logic [N-1:0] domain_rst, domain_rst2;
  logic [2:0] state_o, state2;
  logic [7:0] lock_loss_cnt;
  logic [1:0] loss2;
  int checks = 0, passed = 0;
  int e_st[MAXT];
  logic [N-1:0] e_dr[MAXT];
  bit e_rdy[MAXT];
  int e_loss[MAXT];
  bit lk_in[MAXT], rc_in[MAXT], rs_in[MAXT];
  pll_reset_sequencer #(.NUM_DOMAINS(N), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STB),
    .STAGGER_CYCLES(STG), .MAX_RETRIES(MAXR), .LOSS_W(8)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .reconfig_req(reconfig_req),
    .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready), .fault(fault),
    .state_o(state_o), .lock_loss_cnt(lock_loss_cnt));
  pll_reset_sequencer #(.NUM_DOMAINS(N), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STB),
    .STAGGER_CYCLES(STG), .MAX_RETRIES(MAXR), .LOSS_W(2)) dut2 (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .reconfig_req(reconfig_req),
    .pll_rst(pll_rst2), .domain_rst(domain_rst2), .ready(ready2), .fault(fault2),
    .state_o(state2), .lock_loss_cnt(loss2));
  always #5 refclk = ~refclk;
  task automatic step();
    @(posedge refclk);
    #1;
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    reconfig_req = 1'b0;
    step();
  endtask
  function automatic int tr_of(int tw, int ls);
    return ((ls > tw) ? ls : tw) + 1 + STB;
  endfunction
  function automatic void clear_plan();
    for (int t = 0; t < MAXT; t++) begin
      e_st[t] = 0; e_dr[t] = '1; e_rdy[t] = 0; e_loss[t] = 0;
      lk_in[t] = 0; rc_in[t] = 0; rs_in[t] = 0;
    end
  endfunction
  function automatic void plan_wait(int tw, int ls);
    int tr;
    tr = tr_of(tw, ls);
    for (int t = tw; t < MAXT; t++) begin
      e_st[t] = (t < tr - STB) ? 1 : (t < tr) ? 2 : (t < tr + N * STG) ? 3 : 4;
      for (int i = 0; i < N; i++) e_dr[t][i] = (t < tr + STG * (i + 1));
      e_rdy[t] = (t > tr + N * STG);
    end
  endfunction
  function automatic void plan_rst(int t0, int ls);
    for (int t = t0; t < t0 + RSTC && t < MAXT; t++) begin
      e_st[t] = 0; e_dr[t] = '1; e_rdy[t] = 0;
    end
    plan_wait(t0 + RSTC, ls);
  endfunction
  function automatic void plan_timeouts(int t0);
    int k;
    for (int t = t0; t < MAXT; t++) begin
      k = (t - t0) / (RSTC + TMO);
      e_st[t] = (k > MAXR) ? 5 : (((t - t0) % (RSTC + TMO)) < RSTC) ? 0 : 1;
      e_dr[t] = '1;
      e_rdy[t] = 0;
    end
  endfunction
  function automatic void set_loss(int from, int v);
    for (int t = from; t < MAXT; t++) e_loss[t] = v;
  endfunction
  function automatic void set_lock(int from, bit v);
    for (int t = from; t < MAXT; t++) lk_in[t] = v;
  endfunction
  function automatic void drop_lock(int f, int d);
    for (int t = f - 2; t < f - 2 + d; t++) lk_in[t] = 0;
  endfunction
  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b1; reconfig_req = 1'b1;
    step(); step();
    checks++; if (state_o !== 3'd0) $display("FAIL reset_state got %0d exp 0", state_o); else passed++;
    checks++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst got %b exp 1", pll_rst); else passed++;
    checks++; if (domain_rst !== 4'hF) $display("FAIL reset_domain_rst got %h exp f", domain_rst); else passed++;
    checks++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else passed++;
    checks++; if (fault !== 1'b0) $display("FAIL reset_fault got %b exp 0", fault); else passed++;
    checks++; if (lock_loss_cnt !== 8'd0) $display("FAIL reset_loss got %0d exp 0", lock_loss_cnt); else passed++;
  endtask
  task automatic test_bringup();
    int a, ls, n;
    repeat (3) begin
      a = $urandom_range(6, 40);
      ls = a + 2;
      clear_plan();
      set_lock(a, 1);
      plan_rst(0, ls);
      rc_in[$urandom_range(0, RSTC - 1)] = 1;
      n = tr_of(RSTC, ls) + N * STG + 6;
      apply_reset();
      for (int t = 0; t < n; t++) begin
        pll_locked = lk_in[t]; reconfig_req = rc_in[t]; rst = rs_in[t];
        checks++;
        if ({state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt} !==
            {3'(e_st[t]), e_st[t] == 0, e_dr[t], e_rdy[t], e_st[t] == 5, 8'(e_loss[t])})
          $display("FAIL bringup t=%0d got st=%0d prst=%b dr=%h rdy=%b flt=%b loss=%0d exp st=%0d dr=%h rdy=%b loss=%0d",
                   t, state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt, e_st[t], e_dr[t], e_rdy[t], e_loss[t]);
        else passed++;
        step();
      end
    end
  endtask
  task automatic test_glitch();
    int a, ls, f, n;
    repeat (2) begin
      a = $urandom_range(6, 30);
      ls = a + 2;
      f = tr_of(RSTC, ls) - STB + $urandom_range(0, STB - 1);
      clear_plan();
      set_lock(a, 1);
      drop_lock(f, 1);
      plan_rst(0, ls);
      plan_wait(f + 1, f + 1);
      n = tr_of(f + 1, f + 1) + N * STG + 4;
      apply_reset();
      for (int t = 0; t < n; t++) begin
        pll_locked = lk_in[t]; reconfig_req = rc_in[t]; rst = rs_in[t];
        checks++;
        if ({state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt} !==
            {3'(e_st[t]), e_st[t] == 0, e_dr[t], e_rdy[t], e_st[t] == 5, 8'(e_loss[t])})
          $display("FAIL glitch t=%0d got st=%0d prst=%b dr=%h rdy=%b flt=%b loss=%0d exp st=%0d dr=%h rdy=%b loss=%0d",
                   t, state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt, e_st[t], e_dr[t], e_rdy[t], e_loss[t]);
        else passed++;
        step();
      end
    end
  endtask
  task automatic test_loss();
    int a, ls, f, d, n;
    repeat (3) begin
      a = $urandom_range(6, 40);
      ls = a + 2;
      f = tr_of(RSTC, ls) + $urandom_range(0, N * STG + 10);
      d = $urandom_range(1, 8);
      clear_plan();
      set_lock(a, 1);
      drop_lock(f, d);
      plan_rst(0, ls);
      plan_rst(f + 1, f + d);
      set_loss(f + 1, 1);
      n = tr_of(f + 1 + RSTC, f + d) + N * STG + 4;
      apply_reset();
      for (int t = 0; t < n; t++) begin
        pll_locked = lk_in[t]; reconfig_req = rc_in[t]; rst = rs_in[t];
        checks++;
        if ({state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt} !==
            {3'(e_st[t]), e_st[t] == 0, e_dr[t], e_rdy[t], e_st[t] == 5, 8'(e_loss[t])})
          $display("FAIL loss t=%0d got st=%0d prst=%b dr=%h rdy=%b flt=%b loss=%0d exp st=%0d dr=%h rdy=%b loss=%0d",
                   t, state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt, e_st[t], e_dr[t], e_rdy[t], e_loss[t]);
        else passed++;
        step();
      end
    end
  endtask
  task automatic test_timeouts();
    int tf, r, r2, n;
    tf = (MAXR + 1) * (RSTC + TMO);
    r = tf + $urandom_range(10, 20);
    clear_plan();
    plan_timeouts(0);
    set_lock(tf + 5, 1);
    set_lock(r - 2, 0);
    rc_in[r] = 1;
    plan_timeouts(r + 1);
    r2 = r + 1 + tf + $urandom_range(3, 8);
    rc_in[r2] = 1;
    set_lock(r2, 1);
    plan_rst(r2 + 1, r2 + 2);
    n = tr_of(r2 + 1 + RSTC, r2 + 2) + N * STG + 4;
    apply_reset();
    for (int t = 0; t < n; t++) begin
      pll_locked = lk_in[t]; reconfig_req = rc_in[t]; rst = rs_in[t];
      checks++;
      if ({state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt} !==
          {3'(e_st[t]), e_st[t] == 0, e_dr[t], e_rdy[t], e_st[t] == 5, 8'(e_loss[t])})
        $display("FAIL timeouts t=%0d got st=%0d prst=%b dr=%h rdy=%b flt=%b loss=%0d exp st=%0d dr=%h rdy=%b loss=%0d",
                 t, state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt, e_st[t], e_dr[t], e_rdy[t], e_loss[t]);
      else passed++;
      step();
    end
  endtask
  task automatic test_simultaneous();
    int a, ls, f, d, f2, d2, q, n;
    a = $urandom_range(6, 30);
    ls = a + 2;
    clear_plan();
    set_lock(a, 1);
    plan_rst(0, ls);
    f = tr_of(RSTC, ls) + N * STG + $urandom_range(1, 10);
    d = $urandom_range(1, 6);
    drop_lock(f, d);
    rc_in[f] = 1;
    plan_rst(f + 1, f + d);
    f2 = tr_of(f + 1 + RSTC, f + d) + N * STG + $urandom_range(1, 5);
    d2 = $urandom_range(1, 4);
    drop_lock(f2, d2);
    plan_rst(f2 + 1, f2 + d2);
    set_loss(f2 + 1, 1);
    q = tr_of(f2 + 1 + RSTC, f2 + d2) + $urandom_range(0, N * STG - 1);
    rs_in[q] = 1;
    plan_rst(q + 1, q + 3);
    set_loss(q + 1, 0);
    n = tr_of(q + 1 + RSTC, q + 3) + N * STG + 4;
    apply_reset();
    for (int t = 0; t < n; t++) begin
      pll_locked = lk_in[t]; reconfig_req = rc_in[t]; rst = rs_in[t];
      checks++;
      if ({state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt} !==
          {3'(e_st[t]), e_st[t] == 0, e_dr[t], e_rdy[t], e_st[t] == 5, 8'(e_loss[t])})
        $display("FAIL simultaneous t=%0d got st=%0d prst=%b dr=%h rdy=%b flt=%b loss=%0d exp st=%0d dr=%h rdy=%b loss=%0d",
                 t, state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt, e_st[t], e_dr[t], e_rdy[t], e_loss[t]);
      else passed++;
      step();
    end
  endtask
  task automatic test_saturation();
    int a, tw, lsc, f, d, n;
    a = $urandom_range(6, 40);
    clear_plan();
    set_lock(a, 1);
    plan_rst(0, a + 2);
    tw = RSTC;
    lsc = a + 2;
    for (int k = 0; k < 5; k++) begin
      f = tr_of(tw, lsc) + $urandom_range(0, 20);
      d = $urandom_range(1, 5);
      drop_lock(f, d);
      plan_rst(f + 1, f + d);
      set_loss(f + 1, k + 1);
      tw = f + 1 + RSTC;
      lsc = f + d;
    end
    n = tr_of(tw, lsc) + N * STG + 4;
    apply_reset();
    for (int t = 0; t < n; t++) begin
      pll_locked = lk_in[t]; reconfig_req = rc_in[t]; rst = rs_in[t];
      checks++;
      if ({state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt} !==
          {3'(e_st[t]), e_st[t] == 0, e_dr[t], e_rdy[t], e_st[t] == 5, 8'(e_loss[t])})
        $display("FAIL saturation t=%0d got st=%0d prst=%b dr=%h rdy=%b flt=%b loss=%0d exp st=%0d dr=%h rdy=%b loss=%0d",
                 t, state_o, pll_rst, domain_rst, ready, fault, lock_loss_cnt, e_st[t], e_dr[t], e_rdy[t], e_loss[t]);
      else passed++;
      checks++;
      if ({state2, pll_rst2, domain_rst2, ready2, fault2, loss2} !==
          {3'(e_st[t]), e_st[t] == 0, e_dr[t], e_rdy[t], e_st[t] == 5, 2'((e_loss[t] > 3) ? 3 : e_loss[t])})
        $display("FAIL saturation_w2 t=%0d got st=%0d dr=%h rdy=%b loss=%0d exp st=%0d dr=%h rdy=%b loss=%0d",
                 t, state2, domain_rst2, ready2, loss2, e_st[t], e_dr[t], e_rdy[t], (e_loss[t] > 3) ? 3 : e_loss[t]);
      else passed++;
      step();
    end
  endtask
  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_loss();
    test_timeouts();
    test_simultaneous();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
